// File: rtl/decrypt_pipe_unshift_unscramble_pkg.sv
// Shared alphabet constants, one-hot helpers and stage payload types for the
// encrypt/decrypt shift-scramble stages.
package encrypt_config;

  localparam int         ALPHA_LEN     = 26;
  localparam logic [7:0] ASCII_UPPER_A = 8'd65;
  localparam logic [7:0] ASCII_LOWER_A = 8'd97;

  typedef logic [ALPHA_LEN-1:0] alpha_onehot_t;

  // S1 -> S2 payload: encoded letter plus the per-beat controls
  typedef struct packed {
    logic [7:0]    raw;
    alpha_onehot_t oh;
    logic          upper;
    logic          alpha;
    logic          shift_en;
    logic [2:0]    amt;
    logic          mode;
  } s1_t;

  // S2 -> S3 payload: xlate set only when the rotated letter is to be emitted
  typedef struct packed {
    logic [7:0]    raw;
    alpha_onehot_t oh;
    logic          upper;
    logic          xlate;
  } s2_t;

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= ASCII_UPPER_A) && (c < ASCII_UPPER_A + 8'd26);
  endfunction

  // Non-letters encode to the all-zero vector.
  function automatic alpha_onehot_t ascii_to_onehot(input logic [7:0] c);
    alpha_onehot_t oh;
    oh = '0;
    for (int i = 0; i < ALPHA_LEN; i++)
      if (c == ASCII_UPPER_A + 8'(i) || c == ASCII_LOWER_A + 8'(i))
        oh[i] = 1'b1;
    return oh;
  endfunction

  // Falls back to the raw byte when no bit is set.
  function automatic logic [7:0] onehot_to_ascii(input alpha_onehot_t oh,
                                                 input logic upper,
                                                 input logic [7:0] raw);
    logic [7:0] r;
    r = raw;
    for (int i = 0; i < ALPHA_LEN; i++)
      if (oh[i])
        r = (upper ? ASCII_UPPER_A : ASCII_LOWER_A) + 8'(i);
    return r;
  endfunction

endpackage

// File: rtl/decrypt_pipe_unshift_unscramble_rotate.sv
// Combinational mod-26 right rotate of a letter one-hot: bit i moves to
// bit (i - amt) mod 26, so low bits wrap into the top of the vector.
module onehot_rotate_right26
  import encrypt_config::*;
(
  input  alpha_onehot_t vec,
  input  logic [2:0]    amt,
  output alpha_onehot_t rot
);

  always_comb begin
    rot = vec;
    case (amt)
      3'd1:    rot = {vec[0:0], vec[25:1]};
      3'd2:    rot = {vec[1:0], vec[25:2]};
      3'd3:    rot = {vec[2:0], vec[25:3]};
      3'd4:    rot = {vec[3:0], vec[25:4]};
      3'd5:    rot = {vec[4:0], vec[25:5]};
      3'd6:    rot = {vec[5:0], vec[25:6]};
      3'd7:    rot = {vec[6:0], vec[25:7]};
      default: rot = vec;
    endcase
  end

endmodule

// File: rtl/decrypt_pipe_unshift_unscramble.sv
// Decrypt tail stage: classify/encode, rotate right by shift_amt, decode.
// Three registered stages with a valid/ready chain back from out_ready.
module decrypt_pipe_unshift_unscramble
  import encrypt_config::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       in_ready,
  input  logic [7:0] data_in,
  input  logic       shift_en,
  input  logic [2:0] shift_amt,
  input  logic       mode,
  output logic       en_out,
  input  logic       out_ready,
  output logic [7:0] data_out
);

  logic [3:1]    vld_pipe;
  s1_t           s1_d, s1_q;
  s2_t           s2_d, s2_q;
  alpha_onehot_t oh_rot;
  logic [7:0]    s3_d;
  logic          rdy1, rdy2, rdy3;

  // A stage may load when it is empty or its contents move on this cycle.
  assign rdy3     = !vld_pipe[3] || out_ready;
  assign rdy2     = !vld_pipe[2] || rdy3;
  assign rdy1     = !vld_pipe[1] || rdy2;
  assign in_ready = rdy1;
  assign en_out   = vld_pipe[3];

  always_comb begin
    s1_d          = '0;
    s1_d.raw      = data_in;
    s1_d.oh       = ascii_to_onehot(data_in);
    s1_d.upper    = is_upper(data_in);
    s1_d.alpha    = |s1_d.oh;
    s1_d.shift_en = shift_en;
    s1_d.amt      = shift_amt;
    s1_d.mode     = mode;
  end

  onehot_rotate_right26 u_rot (
    .vec (s1_q.oh),
    .amt (s1_q.amt),
    .rot (oh_rot)
  );

  always_comb begin
    s2_d       = '0;
    s2_d.raw   = s1_q.raw;
    s2_d.upper = s1_q.upper;
    s2_d.xlate = s1_q.alpha && !s1_q.mode && s1_q.shift_en;
    s2_d.oh    = s2_d.xlate ? oh_rot : s1_q.oh;
  end

  assign s3_d = s2_q.xlate ? onehot_to_ascii(s2_q.oh, s2_q.upper, s2_q.raw)
                           : s2_q.raw;

  // Payload registers only load with a valid beat so data_out holds when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      data_out <= 8'h00;
    end else begin
      if (rdy1) begin
        vld_pipe[1] <= en;
        if (en) s1_q <= s1_d;
      end
      if (rdy2) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) s2_q <= s2_d;
      end
      if (rdy3) begin
        vld_pipe[3] <= vld_pipe[2];
        if (vld_pipe[2]) data_out <= s3_d;
      end
    end
  end

endmodule
